id_scoreboard: RTL
==================

# id_scoreboard

Parametrised hazard/forwarding scoreboard for the decode stage. It replaces the fixed three-stage compare/hazard pairing with a configurable-depth shift register of in-flight writers. It adds tracking of one long-latency multicycle op (mul/div) with RAW, WAW and structural stalls. It sits beside the ID/EX register and drives its stall (`hz`) and forwarding selects.

## Interface
Parameters:
- `DEPTH`, 3, number of tracked stages after ID (entry 1 = EX, entry 2 = MEM, …, entry DEPTH = WB); legal range 2..6.
- `MC_LAT`, 16, maximum multicycle latency in cycles; `LW = $clog2(MC_LAT+1)`.
- `SW = $clog2(DEPTH+1)`, derived width of the forwarding selects.

Ports:
- `clk` in 1: system clock.
- `Rst` in 1: reset, asynchronous and active-low.
- `dbg` in 1: debug freeze; when 1, all state holds.
- `mem_hold` in 1: memory freeze; when 1, all state holds.
- `flush` in 1: kills the instruction currently in ID (branch taken or trap).
- `issue_valid` in 1: ID holds a real instruction.
- `issue_rd` in 5: destination register.
- `issue_regwrite` in 1: instruction writes `rd`.
- `issue_memread` in 1: instruction is a load.
- `issue_mc` in 1: instruction is a multicycle op.
- `issue_mc_lat` in LW: latency of the multicycle op.
- `rs1`, `rs2` in 5 each: source register addresses.
- `use_rs1`, `use_rs2` in 1 each: operand is actually read.
- `early` in 1: operands are needed in ID (branch/jalr compare) rather than in EX.
- `hz` out 1: stall ID and insert a bubble.
- `fwd_sel1`, `fwd_sel2` out SW each: 0 = register file; k = youngest matching entry k.
- `mc_busy` out 1: multicycle op outstanding.
- `mc_rd` out 5: destination of the outstanding multicycle op.
- `mc_done` out 1: one-cycle pulse when the multicycle result is written back.

## Operation
- State is `entry[1..DEPTH]`, each holding {valid, rd, regwrite, memread}. State also includes the multicycle counter `mc_cnt` (LW bits) and `mc_rd_q`.
- Advance condition: `adv = !dbg && !mem_hold`. On each `adv` edge, `entry[k+1] <= entry[k]` and `entry[DEPTH]` retires.
- `entry[1]` loads the ID instruction when `issue_valid && !hz && !flush`; otherwise it loads a bubble (valid = 0).
- A match requires valid && regwrite && rd == rs && rs != 0 && the operand's `use` bit. x0 never matches.
- RAW stall on a normal (`early = 0`) operand: match in entry 1 with memread = 1.
- RAW stall on an early operand:
  - any match in entry 1;
  - a match in entry 2 with memread = 1.
- Multicycle stalls apply when `mc_busy`:
  - RAW: a used source equals `mc_rd_q` (nonzero);
  - WAW: `issue_regwrite && issue_rd == mc_rd_q`;
  - structural: `issue_mc`.
- `hz` is the OR of all stall terms, gated by `issue_valid && !flush`. `hz` is combinational.
- Forwarding: `fwd_selN` is the lowest k with a match; 0 if there is none. It is valid whether or not `hz` is asserted.
- Multicycle accept: `issue_mc && issue_regwrite && issue_rd != 0 && issue_valid && !hz && !flush && adv`.
  - On accept, `mc_cnt <= max(issue_mc_lat, 1)` and `mc_rd_q <= issue_rd`.
  - An accepted mc op enters entry 1 with regwrite forced to 0, so the scoreboard tracks it only via `mc_cnt`.
- Counter: decrements on each `adv` edge while nonzero. `mc_done` = (`mc_cnt == 1 && adv`). The counter reaches 0 on that edge.
- `mc_busy = (mc_cnt != 0)`. `mc_rd = mc_rd_q`.
- Flush never cancels an accepted mc op or any entry already in 1..DEPTH.

## Timing
- Reset (asynchronous, while `Rst` = 0):
  - all entries invalid, `mc_cnt` = 0, `mc_rd_q` = 0;
  - outputs: `hz` = 0, `fwd_sel1`/`fwd_sel2` = 0, `mc_busy` = 0, `mc_rd` = 0, `mc_done` = 0.
- Reset mid-multicycle op: `mc_busy` drops immediately and no `mc_done` pulse is produced.
- Latency:
  - `hz` and `fwd_sel` follow the inputs and state in the same cycle;
  - state updates on the next `adv` edge.
- Load-use stalls:
  - normal operand: exactly 1 cycle;
  - early operand: 2 cycles.
- ALU-to-early-branch stall: 1 cycle.
- Multicycle op with latency L accepted at edge t: `mc_done` is high in the cycle before edge t+L. Its consumer's `hz` deasserts in the cycle after edge t+L.
- Freeze (`dbg` or `mem_hold`): entries and `mc_cnt` hold; outputs remain combinationally valid.
- `flush` together with `hz`: `flush` wins; `hz` = 0 and a bubble enters.

## Configuration
- `SCOREBOARD_MC_EN` defined: multicycle tracking as specified above.
- `SCOREBOARD_MC_EN` undefined:
  - `mc_cnt`/`mc_rd_q` are not built;
  - `issue_mc` and `issue_mc_lat` are ignored, and mc ops are tracked as ordinary entries;
  - `mc_busy`, `mc_done` and `mc_rd` are tied to 0.

## Test plan
- ALU forward: add x5 in entry 1; ID reads rs1 = x5 with early = 0 -> `hz` = 0, `fwd_sel1` = 1.
- Load-use: lw x5 accepted; next cycle ID reads rs2 = x5 -> `hz` = 1 for one cycle; then `hz` = 0 and `fwd_sel2` = 2.
- Early branch: lw x6 then beq x6 with early = 1 -> `hz` = 1 for 2 cycles; then `fwd_sel1` = 3 (DEPTH = 3).
- Multicycle: div x7 with lat = 4:
  - `mc_busy` = 1 and `mc_rd` = 7;
  - a following add reading x7 stalls;
  - `mc_done` pulses once, 4 edges after accept, and `hz` drops in the next cycle;
  - a second mul issued while busy sees `hz` = 1.
- x0 and freeze:
  - writer to x0 followed by a reader of x0 -> `hz` = 0, `fwd_sel` = 0;
  - with `dbg` = 1 for 5 cycles, `mc_cnt` and all entries are unchanged.
- Async reset mid-div (`mc_cnt` = 3): assert `Rst` = 0 between edges -> `mc_busy` = 0 immediately; no `mc_done` after release.

Source files
------------

// File: rtl/id_scoreboard.sv
// Decode-stage hazard/forwarding scoreboard: a DEPTH-deep shift register of in-flight writers,
// plus optional tracking of one long-latency op (enabled by defining SCOREBOARD_MC_EN).
module id_scoreboard #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned MC_LAT = 16,
  localparam int unsigned LW    = $clog2(MC_LAT + 1),
  localparam int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          dbg,
  input  logic          mem_hold,
  input  logic          flush,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  input  logic          issue_regwrite,
  input  logic          issue_memread,
  input  logic          issue_mc,
  input  logic [LW-1:0] issue_mc_lat,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic          use_rs1,
  input  logic          use_rs2,
  input  logic          early,
  output logic          hz,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2,
  output logic          mc_busy,
  output logic [4:0]    mc_rd,
  output logic          mc_done
);

  // Entry k is indexed 1..DEPTH: 1 = EX, DEPTH = WB.
  logic [DEPTH:1] val_q, val_d, rw_q, rw_d, mr_q, mr_d;
  logic [4:0]     rd_q [DEPTH:1];
  logic [4:0]     rd_d [DEPTH:1];
  logic [DEPTH:1] m1, m2;

  logic adv, load, stall_rs1, stall_rs2, mc_stall, mc_acc;

  assign adv  = !dbg && !mem_hold;
  assign load = issue_valid && !hz && !flush;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      m1[k] = val_q[k] && rw_q[k] && (rd_q[k] == rs1) && (rs1 != 5'd0) && use_rs1;
      m2[k] = val_q[k] && rw_q[k] && (rd_q[k] == rs2) && (rs2 != 5'd0) && use_rs2;
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (m1[k]) fwd_sel1 = SW'(k);
      if (m2[k]) fwd_sel2 = SW'(k);
    end
  end

  always_comb begin
    if (early) begin
      stall_rs1 = m1[1] || (m1[2] && mr_q[2]);
      stall_rs2 = m2[1] || (m2[2] && mr_q[2]);
    end else begin
      stall_rs1 = m1[1] && mr_q[1];
      stall_rs2 = m2[1] && mr_q[1];
    end
  end

  assign hz = issue_valid && !flush && (stall_rs1 || stall_rs2 || mc_stall);

`ifdef SCOREBOARD_MC_EN
  logic [LW-1:0] mc_cnt_q, mc_cnt_d;
  logic [4:0]    mc_rd_q, mc_rd_d;

  assign mc_busy = (mc_cnt_q != '0);
  assign mc_rd   = mc_rd_q;
  assign mc_done = adv && (mc_cnt_q == LW'(1));

  assign mc_stall = mc_busy && (
      (use_rs1 && (rs1 != 5'd0) && (rs1 == mc_rd_q)) ||
      (use_rs2 && (rs2 != 5'd0) && (rs2 == mc_rd_q)) ||
      (issue_regwrite && (issue_rd == mc_rd_q)) ||
      issue_mc);

  assign mc_acc = issue_mc && issue_regwrite && (issue_rd != 5'd0) && load && adv;

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    mc_rd_d  = mc_rd_q;
    if (mc_acc) begin
      mc_cnt_d = (issue_mc_lat == '0) ? LW'(1) : issue_mc_lat;
      mc_rd_d  = issue_rd;
    end else if (adv && mc_busy) begin
      mc_cnt_d = mc_cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      mc_cnt_q <= '0;
      mc_rd_q  <= '0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
      mc_rd_q  <= mc_rd_d;
    end
  end
`else
  logic unused_mc;
  assign unused_mc = ^{issue_mc, issue_mc_lat};
  assign mc_stall  = 1'b0;
  assign mc_acc    = 1'b0;
  assign mc_busy   = 1'b0;
  assign mc_rd     = 5'd0;
  assign mc_done   = 1'b0;
`endif

  always_comb begin
    val_d = val_q;
    rw_d  = rw_q;
    mr_d  = mr_q;
    rd_d  = rd_q;
    if (adv) begin
      for (int k = 2; k <= DEPTH; k++) begin
        val_d[k] = val_q[k-1];
        rw_d[k]  = rw_q[k-1];
        mr_d[k]  = mr_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      // An accepted multicycle op is tracked by the counter, not as a forwardable writer.
      val_d[1] = load;
      rw_d[1]  = load && issue_regwrite && !mc_acc;
      mr_d[1]  = load && issue_memread;
      rd_d[1]  = load ? issue_rd : 5'd0;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      val_q <= '0;
      rw_q  <= '0;
      mr_q  <= '0;
      for (int k = 1; k <= DEPTH; k++) rd_q[k] <= 5'd0;
    end else begin
      val_q <= val_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      rd_q  <= rd_d;
    end
  end

endmodule
